bcd_to_bin_8bit: RTL and testbench
==================================

BCD_TO_BIN_8BIT -- requirements
Module: bcd_to_bin_8bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; ports are listed one per line as name, direction, width, meaning.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  conversion request; sampled only in IDLE.
REQ-005 centena_in  input  4  BCD hundreds digit.
REQ-006 dezena_in  input  4  BCD tens digit.
REQ-007 unidade_in  input  4  BCD units digit.
REQ-008 S  output  8  binary result, registered.
REQ-009 overflow  output  1  the BCD value exceeded 255, registered.
REQ-010 err_digit  output  1  at least one input digit exceeded 9, registered.
REQ-011 busy  output  1  high whenever the state is not IDLE.
REQ-012 done  output  1  one-cycle pulse when S, overflow and err_digit update.
REQ-013 The block SHALL have no parameters.

Function
REQ-014 The FSM SHALL have the states IDLE, CONV and DONE, and SHALL be encoded in 2 bits.
REQ-015 IDLE with start=1 at edge k: latch the three digits, clear the 10-bit accumulator acc, set step=0, go to CONV.
REQ-016 In IDLE with start=0, the FSM SHALL remain in IDLE.
REQ-017 CONV SHALL run exactly 3 cycles (edges k+1, k+2, k+3); each edge computes acc <= acc*10 + digit[step], with the digit order centena, dezena, unidade.
REQ-018 acc*10 SHALL be computed as (acc<<3)+(acc<<1), 10-bit unsigned; the maximum legal value is 999, so there is no internal wrap.
REQ-019 At edge k+3 the block SHALL register the outputs, set done=1 and go to DONE.
REQ-020 DONE SHALL last one cycle; at edge k+4 the block SHALL return to IDLE and clear done.
REQ-021 Latency: results are valid and done=1 in the cycle following edge k+3 (3 clocks after the start edge); throughput is one conversion per 5 cycles.
REQ-022 When the final value is 256..999: overflow=1 and S saturates to 8'hFF.
REQ-023 When the final value is 0..255: overflow=0 and S equals the value.
REQ-024 Any latched digit greater than 9 (values 0xA..0xF): err_digit=1, S=8'h00, overflow=0; the latency is unchanged (the path still takes 3 CONV cycles).
REQ-025 When err_digit=0, S and overflow SHALL follow REQ-022 and REQ-023.
REQ-026 start asserted in CONV or DONE SHALL be ignored; it is not queued.
REQ-027 Digit inputs SHALL be ignored except on the accepting edge; changes during CONV SHALL not affect the result.
REQ-028 S, overflow and err_digit SHALL hold their values until the next done pulse.
REQ-029 busy SHALL be 1 in CONV and DONE, and 0 in IDLE.
REQ-030 start held high continuously SHALL start a new conversion on each IDLE entry, i.e. every 5 cycles.

Reset
REQ-031 rst_n=0 SHALL immediately, with no clock edge, force: state=IDLE, acc=0, step=0, S=0, overflow=0, err_digit=0, done=0, busy=0.
REQ-032 Reset during CONV or DONE SHALL abort the conversion; no done pulse SHALL follow for the aborted conversion.
REQ-033 After rst_n rises, the first start sampled at a rising edge SHALL be accepted normally.

Verification
REQ-034 The bench SHALL cover scenario 1: C=2,D=5,U=5, start pulse -> 3 clocks later done=1, S=8'hFF, overflow=0, err_digit=0.
REQ-035 The bench SHALL cover scenario 2: 2,5,6 -> S=8'hFF, overflow=1; 9,9,9 -> S=8'hFF, overflow=1; 0,0,0 -> S=8'h00; 1,2,8 -> S=8'h80.
REQ-036 The bench SHALL cover scenario 3: C=1,D=0xA,U=3 -> done after 3 clocks, err_digit=1, S=8'h00, overflow=0; then 0,4,2 -> S=8'h2A, err_digit=0.
REQ-037 The bench SHALL cover scenario 4: start 1,0,0 and, on the next edge, change the digits to 9,9,9 while pulsing start again -> single done, S=8'h64, second start ignored.
REQ-038 The bench SHALL cover scenario 5: start 2,0,0, assert rst_n=0 at step 1 -> outputs 0 asynchronously, no done; release, start 0,1,7 -> S=8'h11.
REQ-039 The bench SHALL cover scenario 6: an exhaustive sweep of all 1000 legal BCD triples plus a sample of invalid digits, compared against a reference model including the saturation and error rules.

Source files
------------

// File: rtl/bcd_to_bin_8bit.sv
// Three-digit BCD to 8-bit binary converter: serial multiply-accumulate over three
// cycles, saturating at 8'hFF, with an invalid-digit error flag.
module bcd_to_bin_8bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] centena_in,
    input  logic [3:0] dezena_in,
    input  logic [3:0] unidade_in,
    output logic [7:0] S,
    output logic       overflow,
    output logic       err_digit,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t     state_r;
    logic [9:0] acc_r;
    logic [1:0] step_r;
    logic [3:0] cen_r;
    logic [3:0] dez_r;
    logic [3:0] uni_r;

    logic [3:0] digit_s;
    logic [9:0] next_acc_s;
    logic       bad_s;

    function automatic logic [9:0] times_ten(input logic [9:0] v);
        return (v << 3) + (v << 1);
    endfunction

    function automatic logic digit_invalid(input logic [3:0] d);
        return d > 4'd9;
    endfunction

    // Select the digit for the current step and form the next accumulator value
    always_comb begin
        digit_s = 4'd0;
        case (step_r)
            2'd0:    digit_s = cen_r;
            2'd1:    digit_s = dez_r;
            default: digit_s = uni_r;
        endcase
        next_acc_s = times_ten(acc_r) + {6'd0, digit_s};
        bad_s      = digit_invalid(cen_r) | digit_invalid(dez_r) | digit_invalid(uni_r);
    end

    // busy is decoded from the state register alone, so it carries no combinational input path
    assign busy = (state_r != IDLE);

    // Conversion FSM with registered results and done pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            acc_r     <= 10'd0;
            step_r    <= 2'd0;
            cen_r     <= 4'd0;
            dez_r     <= 4'd0;
            uni_r     <= 4'd0;
            S         <= 8'h00;
            overflow  <= 1'b0;
            err_digit <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        cen_r   <= centena_in;
                        dez_r   <= dezena_in;
                        uni_r   <= unidade_in;
                        acc_r   <= 10'd0;
                        step_r  <= 2'd0;
                        state_r <= CONV;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                CONV: begin
                    acc_r  <= next_acc_s;
                    step_r <= step_r + 2'd1;
                    if (step_r == 2'd2) begin
                        done    <= 1'b1;
                        state_r <= DONE;
                        // Invalid digits take priority; the accumulator may wrap in that case
                        if (bad_s) begin
                            S         <= 8'h00;
                            overflow  <= 1'b0;
                            err_digit <= 1'b1;
                        end else if (next_acc_s > 10'd255) begin
                            S         <= 8'hFF;
                            overflow  <= 1'b1;
                            err_digit <= 1'b0;
                        end else begin
                            S         <= next_acc_s[7:0];
                            overflow  <= 1'b0;
                            err_digit <= 1'b0;
                        end
                    end else begin
                        state_r <= CONV;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_to_bin_8bit.sv
// Randomised and directed self-checking bench for bcd_to_bin_8bit against an
// arithmetic reference model.
module tb_bcd_to_bin_8bit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] centena_in;
    logic [3:0] dezena_in;
    logic [3:0] unidade_in;
    logic [7:0] S;
    logic       overflow;
    logic       err_digit;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;

    bcd_to_bin_8bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .centena_in (centena_in),
        .dezena_in  (dezena_in),
        .unidade_in (unidade_in),
        .S          (S),
        .overflow   (overflow),
        .err_digit  (err_digit),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] u;
        logic [7:0] s;
        logic       ov;
        logic       er;
    } vec_t;

    // Reference: decimal value from digits, then error / saturation rules
    function automatic void model(input int c, input int d, input int u,
                                  output logic [7:0] s, output logic ov, output logic er);
        int v;
        v  = c * 100 + d * 10 + u;
        er = (c > 9) || (d > 9) || (u > 9);
        if (er) begin
            s  = 8'h00;
            ov = 1'b0;
        end else if (v > 255) begin
            s  = 8'hFF;
            ov = 1'b1;
        end else begin
            s  = v[7:0];
            ov = 1'b0;
        end
    endfunction

    // Pulse start for one edge, then wait (bounded) for done; lat counts clocks after the start edge
    task automatic apply(input logic [3:0] c, input logic [3:0] d, input logic [3:0] u,
                         output logic [7:0] s, output logic ov, output logic er, output int lat);
        @(negedge clk);
        start      = 1'b1;
        centena_in = c;
        dezena_in  = d;
        unidade_in = u;
        @(negedge clk);
        start = 1'b0;
        lat   = 0;
        while (done !== 1'b1 && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        s  = S;
        ov = overflow;
        er = err_digit;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        centena_in = 4'd0;
        dezena_in  = 4'd0;
        unidade_in = 4'd0;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({S, overflow, err_digit, busy, done} !== 12'h000) begin
            n_err++;
            $display("FAIL reset_state got S=%h ov=%b er=%b busy=%b done=%b expected all 0",
                     S, overflow, err_digit, busy, done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL idle_after_reset busy=%b expected 0", busy);
        end
    endtask

    task automatic test_directed();
        vec_t tbl [7];
        logic [7:0] s;
        logic ov, er;
        int lat;
        tbl[0] = '{4'd2, 4'd5, 4'd5, 8'hFF, 1'b0, 1'b0};
        tbl[1] = '{4'd2, 4'd5, 4'd6, 8'hFF, 1'b1, 1'b0};
        tbl[2] = '{4'd9, 4'd9, 4'd9, 8'hFF, 1'b1, 1'b0};
        tbl[3] = '{4'd0, 4'd0, 4'd0, 8'h00, 1'b0, 1'b0};
        tbl[4] = '{4'd1, 4'd2, 4'd8, 8'h80, 1'b0, 1'b0};
        tbl[5] = '{4'd1, 4'hA, 4'd3, 8'h00, 1'b0, 1'b1};
        tbl[6] = '{4'd0, 4'd4, 4'd2, 8'h2A, 1'b0, 1'b0};
        for (int i = 0; i < 7; i++) begin
            apply(tbl[i].c, tbl[i].d, tbl[i].u, s, ov, er, lat);
            n_vec++;
            if (lat !== 3) begin
                n_err++;
                $display("FAIL directed_latency[%0d] got %0d expected 3", i, lat);
            end
            n_vec++;
            if ({s, ov, er} !== {tbl[i].s, tbl[i].ov, tbl[i].er}) begin
                n_err++;
                $display("FAIL directed_result[%0d] got S=%h ov=%b er=%b expected S=%h ov=%b er=%b",
                         i, s, ov, er, tbl[i].s, tbl[i].ov, tbl[i].er);
            end
            n_vec++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL directed_busy[%0d] busy=%b expected 1 in DONE", i, busy);
            end
        end
    endtask

    task automatic test_ignore_start();
        int dones;
        logic [7:0] s_at_done;
        dones = 0;
        s_at_done = 8'h00;
        @(negedge clk);
        start = 1'b1;
        centena_in = 4'd1;
        dezena_in  = 4'd0;
        unidade_in = 4'd0;
        @(negedge clk);
        centena_in = 4'd9;
        dezena_in  = 4'd9;
        unidade_in = 4'd9;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) begin
                dones++;
                s_at_done = S;
            end
            @(negedge clk);
        end
        n_vec++;
        if (dones !== 1) begin
            n_err++;
            $display("FAIL ignore_start_done_count got %0d expected 1", dones);
        end
        n_vec++;
        if (s_at_done !== 8'h64) begin
            n_err++;
            $display("FAIL ignore_start_result got S=%h expected 64", s_at_done);
        end
        n_vec++;
        if (S !== 8'h64) begin
            n_err++;
            $display("FAIL result_hold got S=%h expected 64", S);
        end
    endtask

    task automatic test_reset_abort();
        int dones;
        logic [7:0] s;
        logic ov, er;
        int lat;
        dones = 0;
        @(negedge clk);
        start = 1'b1;
        centena_in = 4'd2;
        dezena_in  = 4'd0;
        unidade_in = 4'd0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_vec++;
        if ({S, overflow, err_digit, busy, done} !== 12'h000) begin
            n_err++;
            $display("FAIL async_reset got S=%h ov=%b er=%b busy=%b done=%b expected all 0",
                     S, overflow, err_digit, busy, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        n_vec++;
        if (dones !== 0) begin
            n_err++;
            $display("FAIL abort_no_done got %0d done pulses expected 0", dones);
        end
        apply(4'd0, 4'd1, 4'd7, s, ov, er, lat);
        n_vec++;
        if ({s, ov, er, lat[3:0]} !== {8'h11, 1'b0, 1'b0, 4'd3}) begin
            n_err++;
            $display("FAIL after_reset got S=%h ov=%b er=%b lat=%0d expected S=11 ov=0 er=0 lat=3",
                     s, ov, er, lat);
        end
    endtask

    task automatic test_exhaustive();
        logic [7:0] s, es;
        logic ov, er, eov, eer;
        int lat;
        int c, d, u;
        for (int i = 0; i < 1100; i++) begin
            if (i < 1000) begin
                c = i / 100;
                d = (i / 10) % 10;
                u = i % 10;
            end else begin
                c = $urandom_range(0, 15);
                d = $urandom_range(0, 15);
                u = $urandom_range(0, 15);
                case ($urandom_range(0, 2))
                    0:       c = $urandom_range(10, 15);
                    1:       d = $urandom_range(10, 15);
                    default: u = $urandom_range(10, 15);
                endcase
            end
            model(c, d, u, es, eov, eer);
            apply(c[3:0], d[3:0], u[3:0], s, ov, er, lat);
            n_vec++;
            if ({s, ov, er} !== {es, eov, eer} || lat !== 3) begin
                n_err++;
                $display("FAIL sweep %0d,%0d,%0d got S=%h ov=%b er=%b lat=%0d expected S=%h ov=%b er=%b lat=3",
                         c, d, u, s, ov, er, lat, es, eov, eer);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] es;
        logic eov, eer;
        int c, d, u;
        c = $urandom_range(0, 9);
        d = $urandom_range(0, 9);
        u = $urandom_range(0, 9);
        model(c, d, u, es, eov, eer);
        @(negedge clk);
        start = 1'b1;
        centena_in = c[3:0];
        dezena_in  = d[3:0];
        unidade_in = u[3:0];
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            n_vec++;
            if (done !== (cyc % 5 == 4) || busy !== (cyc % 5 != 0)) begin
                n_err++;
                $display("FAIL back_to_back cycle %0d done=%b busy=%b expected done=%b busy=%b",
                         cyc, done, busy, (cyc % 5 == 4), (cyc % 5 != 0));
            end
            if (cyc % 5 == 4) begin
                n_vec++;
                if ({S, overflow, err_digit} !== {es, eov, eer}) begin
                    n_err++;
                    $display("FAIL back_to_back_result cycle %0d got S=%h ov=%b expected S=%h ov=%b",
                             cyc, S, overflow, es, eov);
                end
            end
        end
        start = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if (busy !== 1'b0) begin
            n_err++;
            $display("FAIL start_release busy=%b expected 0", busy);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_directed();
        test_ignore_start();
        test_reset_abort();
        test_exhaustive();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
